sample_acc_relu: RTL and testbench
==================================

SAMPLE_ACC_RELU -- requirements
Module: sample_acc_relu

Interface
REQ-001 SHALL have parameter DATA_W, default 11: product/output width, signed.
REQ-002 SHALL have parameter LEN, default 16, legal range 1..32: number of products per dot-product.
REQ-003 SHALL derive localparam ACC_W = DATA_W + clog2(LEN) + 1, so that the accumulator never overflows.
REQ-004 SHALL have port ap_clk, input, 1: sole clock; all logic rising-edge.
REQ-005 SHALL have port ap_rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port ap_start, input, 1: begin one dot-product.
REQ-007 SHALL have port ap_ready, output, 1: one-cycle pulse when ap_start is accepted.
REQ-008 SHALL have port ap_idle, output, 1: high in IDLE.
REQ-009 SHALL have port ap_done, output, 1: one-cycle pulse on the output handshake.
REQ-010 SHALL have port bias, input, DATA_W, signed: sampled when ap_start is accepted.
REQ-011 SHALL have port prod_dat, input, DATA_W, signed: product from the upstream 6x11 multiplier.
REQ-012 SHALL have port prod_vld, input, 1, and port prod_rdy, output, 1: product handshake.
REQ-013 SHALL have port out_dat, output, DATA_W: ReLU-saturated result, registered.
REQ-014 SHALL have port out_vld, input-side peer out_rdy, input, 1, and out_vld, output, 1: output handshake.
REQ-015 SHALL have port sat_flag, output, 1: high with out_vld when the result was clamped high.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, OUT.
REQ-017 IDLE SHALL drive ap_idle=1 and prod_rdy=0; on ap_start=1 it SHALL load acc=sext(bias), set cnt=0, pulse ap_ready, and go to ACC.
REQ-018 ACC SHALL drive prod_rdy=1; each cycle with prod_vld&prod_rdy SHALL do acc+=sext(prod_dat) and cnt+=1; cycles without prod_vld SHALL leave acc and cnt unchanged.
REQ-019 The handshake with cnt==LEN-1 SHALL register out_dat/sat_flag from the final sum and enter OUT; out_vld=1 on the very next cycle (latency 1).
REQ-020 Clamp: sum<0 -> 0; sum>2^(DATA_W-1)-1 -> 2^(DATA_W-1)-1 with sat_flag=1; otherwise out_dat=sum and sat_flag=0.
REQ-021 OUT SHALL hold out_vld, out_dat and sat_flag stable until out_rdy=1; on out_vld&out_rdy it SHALL pulse ap_done and return to IDLE.
REQ-022 ap_start in ACC or OUT SHALL be ignored; prod_vld in IDLE or OUT SHALL be ignored (prod_rdy=0).
REQ-023 With LEN=1, a single product handshake SHALL complete the sum.
REQ-024 out_vld and prod_rdy SHALL never be high in the same cycle.

Reset
REQ-025 ap_rst_n=0 at a clock edge SHALL force the state to IDLE, acc=0, cnt=0, out_dat=0, out_vld=0, sat_flag=0, ap_ready=0, ap_done=0, prod_rdy=0, and ap_idle=1.
REQ-026 Reset during ACC or OUT SHALL discard the partial sum; the next run SHALL carry no residue.

Structure
REQ-027 Package sample_acc_pkg SHALL hold DATA_W and the state enum type.
REQ-028 The clamp logic SHALL be one combinational sub-module, sample_acc_relu_sat (ACC_W in, DATA_W out plus sat).

Verification (LEN=4, DATA_W=11)
REQ-029 Run bias=5 with products 100, 200, -50, 10 -> out_dat=265, sat_flag=0, out_vld one cycle after the 4th handshake.
REQ-030 Run bias=0 with products 500 x4 -> out_dat=1023, sat_flag=1.
REQ-031 Run bias=-10 with products -100 x4 -> out_dat=0, sat_flag=0.
REQ-032 Hold out_rdy=0 for 5 cycles in OUT -> out_vld, out_dat and sat_flag stay stable; ap_done pulses only on the cycle out_rdy=1.
REQ-033 Drive prod_vld in a 1,0,1,0 pattern -> only handshake cycles are counted; ap_start pulsed during ACC is ignored (no ap_ready).
REQ-034 Assert reset after 2 products, then run bias=0 with products 1,1,1,1 -> out_dat=4.

Source files
------------

// File: rtl/sample_acc_pkg.sv
// Shared width default and FSM state type for the dot-product accumulator with ReLU output.
package sample_acc_pkg;

    localparam int unsigned DATA_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/sample_acc_relu_sat.sv
// ReLU clamp: negative sums become zero and sums too large for a positive DATA_W value saturate.
module sample_acc_relu_sat #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned ACC_W  = 14
) (
    input  logic signed [ACC_W-1:0]  sum,
    output logic        [DATA_W-1:0] dat_c,
    output logic                     sat_c
);

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    // A non-negative sum fits when every bit above the DATA_W-1 magnitude bits is zero.
    always_comb begin
        dat_c = sum[DATA_W-1:0];
        sat_c = 1'b0;
        if (sum[ACC_W-1]) begin
            dat_c = '0;
        end else if (|sum[ACC_W-2:DATA_W-1]) begin
            dat_c = MAX_POS;
            sat_c = 1'b1;
        end
    end

endmodule

// File: rtl/sample_acc_relu.sv
// Accumulates bias plus LEN signed products, then presents the ReLU-clamped sum on a valid/ready port.
module sample_acc_relu #(
    parameter int unsigned DATA_W = sample_acc_pkg::DATA_W,
    parameter int unsigned LEN    = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    output logic                     ap_ready,
    output logic                     ap_idle,
    output logic                     ap_done,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] prod_dat,
    input  logic                     prod_vld,
    output logic                     prod_rdy,
    output logic        [DATA_W-1:0] out_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     sat_flag
);

    import sample_acc_pkg::*;

    localparam int unsigned ACC_W = DATA_W + $clog2(LEN) + 1;
    localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic        [DATA_W-1:0]  out_dat_q, out_dat_d;
    logic                      sat_q, sat_d;
    logic                      out_vld_q, out_vld_d;
    logic                      prod_rdy_q, prod_rdy_d;
    logic                      ap_idle_q, ap_idle_d;

    logic                      prod_hs_c;
    logic signed [ACC_W-1:0]   acc_sum_c;
    logic        [DATA_W-1:0]  clamp_dat_c;
    logic                      clamp_sat_c;

    assign prod_hs_c = prod_vld & prod_rdy_q;
    assign acc_sum_c = acc_q + ACC_W'(prod_dat);

    sample_acc_relu_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .sum   (acc_sum_c),
        .dat_c (clamp_dat_c),
        .sat_c (clamp_sat_c)
    );

    // State register and all datapath/output flops.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_dat_q  <= '0;
            sat_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            prod_rdy_q <= 1'b0;
            ap_idle_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_dat_q  <= out_dat_d;
            sat_q      <= sat_d;
            out_vld_q  <= out_vld_d;
            prod_rdy_q <= prod_rdy_d;
            ap_idle_q  <= ap_idle_d;
        end
    end

    // Next state plus accumulator and product counter.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = ACC;
                    acc_d   = ACC_W'(bias);
                    cnt_d   = '0;
                end
            end
            ACC: begin
                if (prod_hs_c) begin
                    acc_d = acc_sum_c;
                    if (cnt_q == CNT_W'(LEN - 1)) begin
                        state_d = OUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            OUT: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered status follows the next state; the result is captured on the final handshake.
    always_comb begin
        out_vld_d  = (state_d == OUT);
        prod_rdy_d = (state_d == ACC);
        ap_idle_d  = (state_d == IDLE);
        out_dat_d  = out_dat_q;
        sat_d      = sat_q;
        if ((state_q == ACC) && (state_d == OUT)) begin
            out_dat_d = clamp_dat_c;
            sat_d     = clamp_sat_c;
        end
    end

    // Handshake pulses coincide with the accepting cycle and stay low while reset is applied.
    assign ap_ready = ap_rst_n & ap_idle_q & ap_start;
    assign ap_done  = ap_rst_n & out_vld_q & out_rdy;

    assign ap_idle  = ap_idle_q;
    assign prod_rdy = prod_rdy_q;
    assign out_vld  = out_vld_q;
    assign out_dat  = out_dat_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_sample_acc_relu.sv
// Self-checking bench: directed vector table, hand-written corner sequences and random runs against a sum/clamp model.
module tb_sample_acc_relu;

    localparam int DW   = 11;
    localparam int LEN  = 4;
    localparam int MAXV = 1023;

    logic clk = 1'b0;
    logic rst_n;

    logic                 ap_start, ap_ready, ap_idle, ap_done;
    logic                 prod_vld, prod_rdy, out_vld, out_rdy, sat_flag;
    logic signed [DW-1:0] bias, prod_dat;
    logic        [DW-1:0] out_dat;

    logic                 s_start, s_ready, s_idle, s_done;
    logic                 s_pvld, s_prdy, s_ovld, s_ordy, s_sat;
    logic signed [DW-1:0] s_bias, s_pdat;
    logic        [DW-1:0] s_odat;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int b;
        int p0;
        int p1;
        int p2;
        int p3;
        int exp_dat;
        int exp_sat;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    sample_acc_relu #(.DATA_W(DW), .LEN(LEN)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .bias     (bias),
        .prod_dat (prod_dat),
        .prod_vld (prod_vld),
        .prod_rdy (prod_rdy),
        .out_dat  (out_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .sat_flag (sat_flag)
    );

    sample_acc_relu #(.DATA_W(DW), .LEN(1)) dut1 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .ap_start (s_start),
        .ap_ready (s_ready),
        .ap_idle  (s_idle),
        .ap_done  (s_done),
        .bias     (s_bias),
        .prod_dat (s_pdat),
        .prod_vld (s_pvld),
        .prod_rdy (s_prdy),
        .out_dat  (s_odat),
        .out_vld  (s_ovld),
        .out_rdy  (s_ordy),
        .sat_flag (s_sat)
    );

    function automatic int ref_dat(input int s);
        if (s < 0) return 0;
        if (s > MAXV) return MAXV;
        return s;
    endfunction

    function automatic int ref_sat(input int s);
        return (s > MAXV) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full dot-product; gap_max<0 inserts exactly -gap_max idle cycles before every product.
    task automatic run(input int b, input int p0, input int p1, input int p2, input int p3,
                       input int exp_dat, input int exp_sat, input int gap_max, input int stall);
        int p[4];
        int gaps;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        bias     = DW'(b);
        ap_start = 1'b1;
        #1;
        chk("ap_ready_on_start", ap_ready, 1);
        tick();
        ap_start = 1'b0;
        chk("prod_rdy_in_acc", prod_rdy, 1);
        chk("ap_idle_in_acc", ap_idle, 0);
        for (int i = 0; i < 4; i++) begin
            if (gap_max < 0) gaps = -gap_max;
            else if (gap_max > 0) gaps = int'($urandom_range(gap_max, 0));
            else gaps = 0;
            repeat (gaps) begin
                prod_vld = 1'b0;
                prod_dat = DW'($urandom);
                ap_start = 1'b1;
                #1;
                chk("ap_ready_ignored_in_acc", ap_ready, 0);
                tick();
            end
            ap_start = 1'b0;
            prod_vld = 1'b1;
            prod_dat = DW'(p[i]);
            #1;
            chk("out_vld_before_last", out_vld, 0);
            tick();
        end
        prod_vld = 1'b0;
        chk("out_vld_latency", out_vld, 1);
        chk("prod_rdy_excl_out", prod_rdy, 0);
        chk("out_dat", out_dat, exp_dat);
        chk("sat_flag", sat_flag, exp_sat);
        repeat (stall) begin
            out_rdy  = 1'b0;
            prod_vld = 1'b1;
            prod_dat = DW'($urandom);
            #1;
            chk("ap_done_while_stalled", ap_done, 0);
            tick();
            chk("out_vld_held", out_vld, 1);
            chk("out_dat_held", out_dat, exp_dat);
            chk("sat_flag_held", sat_flag, exp_sat);
            chk("prod_rdy_in_out", prod_rdy, 0);
        end
        prod_vld = 1'b0;
        out_rdy  = 1'b1;
        #1;
        chk("ap_done_on_handshake", ap_done, 1);
        tick();
        out_rdy = 1'b0;
        chk("out_vld_after_done", out_vld, 0);
        chk("ap_idle_after_done", ap_idle, 1);
        chk("ap_done_single_pulse", ap_done, 0);
    endtask

    task automatic run1(input int b, input int p, input int exp_dat, input int exp_sat);
        s_bias  = DW'(b);
        s_start = 1'b1;
        #1;
        chk("len1_ap_ready", s_ready, 1);
        tick();
        s_start = 1'b0;
        chk("len1_prod_rdy", s_prdy, 1);
        s_pvld = 1'b1;
        s_pdat = DW'(p);
        tick();
        s_pvld = 1'b0;
        chk("len1_out_vld", s_ovld, 1);
        chk("len1_out_dat", s_odat, exp_dat);
        chk("len1_sat_flag", s_sat, exp_sat);
        s_ordy = 1'b1;
        #1;
        chk("len1_ap_done", s_done, 1);
        tick();
        s_ordy = 1'b0;
        chk("len1_idle", s_idle, 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ap_idle"}, ap_idle, 1);
        chk({tag, "_out_vld"}, out_vld, 0);
        chk({tag, "_prod_rdy"}, prod_rdy, 0);
        chk({tag, "_out_dat"}, out_dat, 0);
        chk({tag, "_sat_flag"}, sat_flag, 0);
        chk({tag, "_ap_ready"}, ap_ready, 0);
        chk({tag, "_ap_done"}, ap_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5,     100,   200,   -50,   10,    265,  0};
        vecs[1] = '{0,     500,   500,   500,   500,   1023, 1};
        vecs[2] = '{-10,   -100,  -100,  -100,  -100,  0,    0};
        vecs[3] = '{-1024, -1024, -1024, -1024, -1024, 0,    0};
        vecs[4] = '{1023,  1023,  1023,  1023,  1023,  1023, 1};
        vecs[5] = '{0,     1023,  0,     0,     0,     1023, 0};
        vecs[6] = '{0,     1023,  1,     0,     0,     1023, 1};
        vecs[7] = '{100,   -100,  0,     0,     0,     0,    0};
        vecs[8] = '{-1,    1,     1,     0,     0,     1,    0};

        rst_n    = 1'b0;
        ap_start = 1'b1;
        bias     = '0;
        prod_dat = '0;
        prod_vld = 1'b1;
        out_rdy  = 1'b1;
        s_start  = 1'b0;
        s_bias   = '0;
        s_pdat   = '0;
        s_pvld   = 1'b0;
        s_ordy   = 1'b0;
        tick();
        tick();
        chk_reset_state("reset");
        chk("len1_reset_idle", s_idle, 1);
        chk("len1_reset_out_vld", s_ovld, 0);
        ap_start = 1'b0;
        prod_vld = 1'b0;
        out_rdy  = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("idle_ignores_prod_vld", prod_rdy, 0);

        foreach (vecs[i])
            run(vecs[i].b, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                vecs[i].exp_dat, vecs[i].exp_sat, 0, 0);

        // Stall the output for five cycles on a saturating result.
        run(0, 500, 500, 500, 500, 1023, 1, 0, 5);
        // Alternating product valid with ignored ap_start pulses in the gaps.
        run(5, 100, 200, -50, 10, 265, 0, -1, 0);

        // Reset after two products, then a clean run must show no residue.
        bias = DW'(0); ap_start = 1'b1; tick(); ap_start = 1'b0;
        prod_vld = 1'b1; prod_dat = DW'(700); tick(); tick();
        prod_vld = 1'b0;
        rst_n = 1'b0; tick();
        chk_reset_state("reset_in_acc");
        rst_n = 1'b1;
        run(0, 1, 1, 1, 1, 4, 0, 0, 0);

        // Reset while holding a result in OUT.
        bias = DW'(0); ap_start = 1'b1; tick(); ap_start = 1'b0;
        prod_vld = 1'b1; prod_dat = DW'(500);
        repeat (4) tick();
        prod_vld = 1'b0;
        chk("out_vld_before_reset", out_vld, 1);
        rst_n = 1'b0; tick();
        chk_reset_state("reset_in_out");
        rst_n = 1'b1;
        run(0, 1, 1, 1, 1, 4, 0, 0, 0);

        run1(5, 7, 12, 0);
        run1(1000, 100, 1023, 1);
        run1(-5, 3, 0, 0);

        for (int r = 0; r < 24; r++) begin
            int b, sum, span;
            int p[4];
            span = (r % 3 == 0) ? 2047 : 511;
            b   = int'($urandom_range(span, 0)) - (span + 1) / 2;
            sum = b;
            for (int k = 0; k < 4; k++) begin
                p[k] = int'($urandom_range(span, 0)) - (span + 1) / 2;
                sum += p[k];
            end
            run(b, p[0], p[1], p[2], p[3], ref_dat(sum), ref_sat(sum), 2, int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
